bundle_parser: RTL
==================

# bundle_parser

Parse stage (stage 1) directly downstream of instruction fetch. Accepts 60-bit two-instruction bundles from fetch, buffers them in a small FIFO, and splits each bundle into its two 30-bit slots. Decodes each slot into its fields and issues at most one non-NOP instruction per cycle to the next stage. Returns the occupied-slot count and a full indication to fetch.

## Interface
- DEPTH, 4, bundle FIFO entries; power of two, minimum 2
- clock_i  in  1  single clock; all state changes on rising edge
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all buffered and in-flight instructions
- enable_i  in  1  data_i carries a valid bundle this cycle
- data_i  in  60  bundle; slot A = [59:30] (issued first), slot B = [29:0]
- stall_i  in  1  downstream cannot accept; hold outputs, no pop
- full_o  out  1  registered; 1 when FIFO count >= DEPTH-1 (one entry headroom for in-flight bundle)
- overflow_o  out  1  sticky; a bundle was dropped
- bundleSize_o  out  4  non-NOP slot count (0..2) of last accepted bundle
- valid_o  out  1  decoded fields below are a real instruction
- format_o  out  1  1 = reg-imm, 0 = reg-reg
- branch_o  out  1  branch flag
- opcode_o  out  7  opcode
- primary_o  out  5  primary register
- secondary_o  out  16  immediate (reg-imm) or zero-extended secondary register (reg-reg)
- slot_o  out  1  0 = slot A, 1 = slot B

## Operation
- Slot layout (30 bits): [29] format, [28] branch, [27:21] opcode, [20:16] primary, [15:0] secondary field.
- secondary_o = slot[15:0] if format=1; {11'b0, slot[15:11]} if format=0.
- A slot is NOP when opcode == 0, regardless of other bits.
- Push: enable_i=1, no flush, and (count < DEPTH or a pop occurs this cycle) -> write at tail. On push, bundleSize_o <= number of non-NOP slots in data_i.
- Push refused (count == DEPTH, no pop) -> bundle dropped, overflow_o <= 1 until reset.
- Issue (stall_i=0, FIFO non-empty), head bundle, slot pointer sp (reset 0):
  - sp=0, A non-NOP: issue A; if B non-NOP set sp=1, else pop.
  - sp=0, A NOP, B non-NOP: issue B, pop.
  - sp=0, both NOP: valid_o <= 0, pop (one cycle).
  - sp=1: issue B, pop, sp <= 0.
- No issue (empty, not stalled) -> valid_o <= 0; fields may hold.
- stall_i=1 -> all output registers and sp hold; pushes still accepted.
- flush_i=1 -> count, head, tail, sp <= 0; valid_o <= 0; enable_i in the same cycle ignored; overflow_o and bundleSize_o hold.
- Priority: reset_i > flush_i > normal operation.

## Timing
- Reset values: valid_o, format_o, branch_o, opcode_o, primary_o, secondary_o, slot_o, full_o, overflow_o, bundleSize_o all 0; FIFO empty, sp=0.
- Latency: bundle pushed at edge N -> first instruction visible on outputs after edge N+1. No bypass.
- Throughput: one instruction per cycle; two-instruction bundle occupies 2 cycles, one-instruction or all-NOP bundle 1 cycle.
- full_o reflects count after the current edge's push/pop.
- Simultaneous push and pop at count == DEPTH: both occur, count unchanged, no overflow.
- Reset mid-bundle (sp=1): remaining slot B discarded, outputs zero next cycle.
- Head/tail pointers wrap modulo DEPTH.

## Test plan
- Reset, push 60'b1_0_0001010_00001_0000000000000101__1_0_0001010_00010_0000000000001010 -> bundleSize_o=2. Next edge: valid_o=1, opcode_o=0x0A, primary_o=1, secondary_o=5, slot_o=0. Following edge: primary_o=2, secondary_o=10, slot_o=1. Then valid_o=0.
- Push 0_0_0000010_00001_00010_00000000000 in A with all-zero B -> one issue: format_o=0, opcode_o=2, primary_o=1, secondary_o=2. bundleSize_o=1. Push all-zero bundle -> bundleSize_o=0, no valid_o, popped in 1 cycle.
- Hold stall_i=1, push DEPTH+1 bundles -> full_o=1 once count reaches 3; 5th bundle dropped and overflow_o=1. Release stall -> exactly 4 bundles issue in order.
- Stall for 3 cycles mid-bundle (sp=1) -> outputs frozen on slot A values; slot B issues on the first unstalled edge.
- flush_i with 2 bundles queued plus enable_i high -> valid_o=0 next edge, nothing issues afterwards, full_o=0.
- reset_i asserted while slot B is pending and enable_i high -> all outputs 0 next edge; overflow_o cleared; new bundle after reset issues normally.

Source files
------------

// File: rtl/bundle_parser.sv
// Parse stage: buffers 60-bit two-slot bundles from fetch and issues at most one
// decoded non-NOP slot per cycle, slot A before slot B.
module bundle_parser #(
  parameter int DEPTH = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        enable_i,
  input  logic [59:0] data_i,
  input  logic        stall_i,
  output logic        full_o,
  output logic        overflow_o,
  output logic [3:0]  bundleSize_o,
  output logic        valid_o,
  output logic        format_o,
  output logic        branch_o,
  output logic [6:0]  opcode_o,
  output logic [4:0]  primary_o,
  output logic [15:0] secondary_o,
  output logic        slot_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH - 1);

  typedef enum logic {SLOT_A = 1'b0, SLOT_B = 1'b1} slot_state_t;

  logic [59:0]   fifo_mem [DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg, count_next;
  slot_state_t   state_reg, state_next;

  logic        valid_reg, format_reg, branch_reg, slot_reg, full_reg, overflow_reg;
  logic [6:0]  opcode_reg;
  logic [4:0]  primary_reg;
  logic [15:0] secondary_reg;
  logic [3:0]  bundle_size_reg;

  logic [59:0] head_bundle;
  logic [29:0] head_slot [2];
  logic [1:0]  head_live, in_live;
  logic [29:0] issue_slot;
  logic        fifo_empty, push, pop, issue, issue_b, clear_valid;

  assign head_bundle = fifo_mem[head_reg];
  assign fifo_empty  = (count_reg == '0);

  // Slot 0 is A (upper half), slot 1 is B; opcode zero marks a NOP
  for (genvar gi = 0; gi < 2; gi++) begin : gen_slot
    assign head_slot[gi] = head_bundle[59-30*gi -: 30];
    assign head_live[gi] = |head_bundle[57-30*gi -: 7];
    assign in_live[gi]   = |data_i[57-30*gi -: 7];
  end

  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    issue       = 1'b0;
    issue_b     = 1'b0;
    clear_valid = 1'b0;
    if (!stall_i) begin
      if (fifo_empty) begin
        clear_valid = 1'b1;
      end else if (state_reg == SLOT_B) begin
        issue      = 1'b1;
        issue_b    = 1'b1;
        pop        = 1'b1;
        state_next = SLOT_A;
      end else if (head_live[0]) begin
        issue = 1'b1;
        if (head_live[1]) state_next = SLOT_B;
        else              pop        = 1'b1;
      end else if (head_live[1]) begin
        issue   = 1'b1;
        issue_b = 1'b1;
        pop     = 1'b1;
      end else begin
        clear_valid = 1'b1;
        pop         = 1'b1;
      end
    end
  end

  // A pop in the same cycle frees the entry a full FIFO needs for this push
  assign push       = enable_i && !flush_i && ((count_reg < DEPTH_C) || pop);
  assign issue_slot = issue_b ? head_slot[1] : head_slot[0];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i && push) fifo_mem[tail_reg] <= data_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      state_reg       <= SLOT_A;
      valid_reg       <= 1'b0;
      format_reg      <= 1'b0;
      branch_reg      <= 1'b0;
      opcode_reg      <= '0;
      primary_reg     <= '0;
      secondary_reg   <= '0;
      slot_reg        <= 1'b0;
      full_reg        <= 1'b0;
      overflow_reg    <= 1'b0;
      bundle_size_reg <= '0;
    end else if (flush_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      state_reg <= SLOT_A;
      valid_reg <= 1'b0;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      full_reg  <= (count_next >= FULL_C);
      if (push) begin
        tail_reg        <= tail_reg + PW'(1);
        bundle_size_reg <= {3'b000, in_live[0]} + {3'b000, in_live[1]};
      end
      if (pop) head_reg <= head_reg + PW'(1);
      if (enable_i && !push) overflow_reg <= 1'b1;
      if (issue) begin
        valid_reg     <= 1'b1;
        format_reg    <= issue_slot[29];
        branch_reg    <= issue_slot[28];
        opcode_reg    <= issue_slot[27:21];
        primary_reg   <= issue_slot[20:16];
        secondary_reg <= issue_slot[29] ? issue_slot[15:0] : {11'b0, issue_slot[15:11]};
        slot_reg      <= issue_b;
      end else if (clear_valid) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign full_o       = full_reg;
  assign overflow_o   = overflow_reg;
  assign bundleSize_o = bundle_size_reg;
  assign valid_o      = valid_reg;
  assign format_o     = format_reg;
  assign branch_o     = branch_reg;
  assign opcode_o     = opcode_reg;
  assign primary_o    = primary_reg;
  assign secondary_o  = secondary_reg;
  assign slot_o       = slot_reg;

endmodule
